// File: rtl/bus_pkg.sv
// Shared CPU bus definitions: data/mask widths and the responder state encoding.
package bus_pkg;

    localparam int BUS_DATA_W = 32;
    localparam int BUS_MASK_W = 4;

    typedef enum logic [1:0] {
        RSP_IDLE,
        RSP_WAIT,
        RSP_RESP,
        RSP_TURN
    } rsp_state_t;

endpackage

// File: rtl/sram_be.sv
// Single-port synchronous RAM with four byte lanes; read data is registered and
// only refreshed on a read, so writes leave the read port untouched.
module sram_be
    import bus_pkg::*;
#(
    parameter int    DEPTH_LOG2 = 12,
    parameter string INIT_FILE  = ""
) (
    input  logic                  clk,
    input  logic [BUS_MASK_W-1:0] i_we,
    input  logic                  i_re,
    input  logic [DEPTH_LOG2-1:0] i_addr,
    input  logic [BUS_DATA_W-1:0] i_wdata,
    output logic [BUS_DATA_W-1:0] o_rdata
);

    logic [BUS_DATA_W-1:0] r_mem [1 << DEPTH_LOG2];
    logic [BUS_DATA_W-1:0] r_rdata;

    // Read-first: a same-edge write is seen by the next read, not this one.
    always_ff @(posedge clk) begin
        if (i_re) r_rdata <= r_mem[i_addr];
        for (int l = 0; l < BUS_MASK_W; l++) begin
            if (i_we[l]) r_mem[i_addr][8*l +: 8] <= i_wdata[8*l +: 8];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/bus_sram_responder.sv
// CPU bus responder: fixed-wait-state front end for a byte-enabled SRAM window.
// Accesses outside the window complete normally but raise bus_err with bus_done.
module bus_sram_responder
    import bus_pkg::*;
#(
    parameter int          DEPTH_LOG2 = 12,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          LATENCY    = 1,
    parameter string       INIT_FILE  = ""
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           bus_addr,
    input  logic [BUS_DATA_W-1:0] bus_wdata,
    input  logic [BUS_MASK_W-1:0] bus_wmask,
    input  logic                  bus_wen,
    input  logic                  bus_ren,
    output logic [BUS_DATA_W-1:0] bus_rdata,
    output logic                  bus_done,
    output logic                  bus_err
);

    localparam int               CNT_W       = $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD    = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(1);
    localparam rsp_state_t       FIRST_STATE = (LATENCY == 1) ? RSP_RESP : RSP_WAIT;

    generate
        if (LATENCY < 1) begin : g_badLatency
            $error("bus_sram_responder: LATENCY must be at least 1");
        end
    endgenerate

    rsp_state_t            r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_done;
    logic                  r_err;
    logic                  r_rdValid;

    logic                  w_req;
    logic                  w_inRange;
    logic                  w_access;
    logic                  w_unusedAddrBits;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic [BUS_MASK_W-1:0] w_ramWe;
    logic                  w_ramRe;
    logic [BUS_DATA_W-1:0] w_ramQ;

    assign w_req            = bus_wen | bus_ren;
    assign w_inRange        = (bus_addr[31:DEPTH_LOG2+2] == BASE_ADDR[31:DEPTH_LOG2+2]);
    assign w_idx            = bus_addr[DEPTH_LOG2+1:2];
    assign w_unusedAddrBits = ^bus_addr[1:0];

    // The RAM is touched only on the edge entering RESP; a reset on that edge cancels it.
    always_comb begin
        w_access = 1'b0;
        if (!rst && w_req) begin
            if (r_state == RSP_IDLE && LATENCY == 1) begin
                w_access = 1'b1;
            end else if (r_state == RSP_WAIT && r_cnt == CNT_LAST) begin
                w_access = 1'b1;
            end
        end
    end

    assign w_ramWe = (w_access && w_inRange && bus_wen) ? bus_wmask : '0;
    assign w_ramRe = w_access && w_inRange && !bus_wen;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= RSP_IDLE;
            r_cnt     <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_rdValid <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                RSP_IDLE: begin
                    if (w_req) begin
                        r_cnt   <= CNT_LOAD;
                        r_state <= FIRST_STATE;
                    end
                end
                RSP_WAIT: begin
                    if (!w_req) begin
                        r_cnt   <= '0;
                        r_state <= RSP_IDLE;
                    end else begin
                        r_cnt <= r_cnt - CNT_LAST;
                        if (r_cnt == CNT_LAST) r_state <= RSP_RESP;
                    end
                end
                RSP_RESP: r_state <= RSP_TURN;
                RSP_TURN: r_state <= RSP_IDLE;
                default:  r_state <= RSP_IDLE;
            endcase
            // Out-of-range accesses force rdata to zero; in-range writes leave it alone.
            if (w_access) begin
                r_done <= 1'b1;
                r_err  <= !w_inRange;
                if (!w_inRange) begin
                    r_rdValid <= 1'b0;
                end else if (!bus_wen) begin
                    r_rdValid <= 1'b1;
                end
            end
        end
    end

    sram_be #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .INIT_FILE  (INIT_FILE)
    ) u_sram (
        .clk     (clk),
        .i_we    (w_ramWe),
        .i_re    (w_ramRe),
        .i_addr  (w_idx),
        .i_wdata (bus_wdata),
        .o_rdata (w_ramQ)
    );

    assign bus_rdata = r_rdValid ? w_ramQ : '0;
    assign bus_done  = r_done;
    assign bus_err   = r_err;

endmodule
